ram_arbiter: RTL

RAM_ARBITER -- requirements
Module: ram_arbiter

---
 rtl/ram_arb_pkg.sv | 26 ++
 rtl/ram_arbiter_if.sv | 34 +++
 rtl/rr_arb2.sv | 40 ++++
 rtl/ram_arbiter.sv | 107 ++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types for the two-port RAM arbiter.
// Holds the FSM state enum, bus widths, the port id and the latched request.
package ram_arb_pkg;

    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        port_id_t          id;
    } req_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: request/response handshake for both requester ports.
// master = requester side (drives valid/we/addr/wdata), slave = arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              p0_valid;
    logic              p0_ready;
    logic              p0_we;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_wdata;
    logic              p0_rsp;

    logic              p1_valid;
    logic              p1_ready;
    logic              p1_we;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_wdata;
    logic              p1_rsp;

    modport master (
        output p0_valid, p0_we, p0_addr, p0_wdata,
        input  p0_ready, p0_rsp,
        output p1_valid, p1_we, p1_addr, p1_wdata,
        input  p1_ready, p1_rsp
    );

    modport slave (
        input  p0_valid, p0_we, p0_addr, p0_wdata,
        output p0_ready, p0_rsp,
        input  p1_valid, p1_we, p1_addr, p1_wdata,
        output p1_ready, p1_rsp
    );

endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way grant. Ports: req[1:0] in, grant[1:0] one-hot out;
// with RAM_ARB_RR_EN also clk, rst, accept (pointer update strobe).
module rr_arb2
    import ram_arb_pkg::*;
(
`ifdef RAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       accept,
`endif
    input  logic [1:0] req,
    output logic [1:0] grant
);

`ifdef RAM_ARB_RR_EN
    // Port served most recently; the other port wins a tie.
    port_id_t last;

    always_ff @(posedge clk) begin
        if (rst)
            last <= PORT1;
        else if (accept)
            last <= port_id_t'(grant[1]);
    end

    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b11:   grant = (last == PORT1) ? 2'b01 : 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end
`else
    // Fixed priority: port 0 always wins.
    assign grant = {req[1] & ~req[0], req[0]};
`endif

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one registered-output RAM between two requesters.
// Ports: clk, rst, bus (ram_arbiter_if.slave), rsp_rdata, busy, ram_* side.
// Define RAM_ARB_RR_EN for round-robin tie-breaking (else port 0 wins).
module ram_arbiter
    import ram_arb_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    ram_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              ram_read,
    output logic              ram_write,
    output logic [ADDR_W-1:0] ram_address,
    output logic [DATA_W-1:0] ram_data,
    input  logic [DATA_W-1:0] ram_out
);

    state_t     state;
    state_t     state_nxt;
    req_t       cur;
    req_t       win_req;
    logic [1:0] req;
    logic [1:0] grant;
    logic       idle;
    logic       accept;
    logic       rsp0_q;
    logic       rsp1_q;

    assign req  = {bus.p1_valid, bus.p0_valid};
    assign idle = (state == IDLE);
    assign busy = ~idle;

    rr_arb2 u_arb (
`ifdef RAM_ARB_RR_EN
        .clk    (clk),
        .rst    (rst),
        .accept (accept),
`endif
        .req    (req),
        .grant  (grant)
    );

    assign bus.p0_ready = idle & grant[0];
    assign bus.p1_ready = idle & grant[1];
    assign bus.p0_rsp   = rsp0_q;
    assign bus.p1_rsp   = rsp1_q;

    assign accept = (bus.p0_valid & bus.p0_ready)
                  | (bus.p1_valid & bus.p1_ready);

    always_comb begin
        if (grant[1])
            win_req = '{we: bus.p1_we, addr: bus.p1_addr,
                        wdata: bus.p1_wdata, id: PORT1};
        else
            win_req = '{we: bus.p0_we, addr: bus.p0_addr,
                        wdata: bus.p0_wdata, id: PORT0};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cur       <= '0;
            rsp0_q    <= 1'b0;
            rsp1_q    <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            state  <= state_nxt;
            rsp0_q <= 1'b0;
            rsp1_q <= 1'b0;
            if (accept)
                cur <= win_req;
            // RAM data is valid in CAPTURE; response fires on exit.
            if (state == CAPTURE) begin
                if (!cur.we)
                    rsp_rdata <= ram_out;
                rsp0_q <= (cur.id == PORT0);
                rsp1_q <= (cur.id == PORT1);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ram_read    = 1'b0;
        ram_write   = 1'b0;
        ram_address = '0;
        ram_data    = '0;
        case (state)
            IDLE: begin
                if (accept)
                    state_nxt = ACCESS;
            end
            ACCESS: begin
                ram_read    = ~cur.we;
                ram_write   = cur.we;
                ram_address = cur.addr;
                ram_data    = cur.wdata;
                state_nxt   = CAPTURE;
            end
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

endmodule
